// File: rtl/commit_stage.sv
// commit_stage: retires exec_result packets from the ALU, one per cycle, through a small
// in-order FIFO. Drives register-file writes, branch redirects, return pulses and trap entry,
// and sequences the post-redirect flush and halt-on-exception states.
// Optional feature: define COMMIT_PERF_EN to add the perf_retired_o / perf_flushes_o counters.

package commit_pkg;
  parameter int unsigned ExW = 8;

  typedef struct packed {
    logic [4:0]     rd_idx;
    logic [31:0]    rd_val;
    logic           br_valid;
    logic [31:0]    br_target;
    logic           ret_valid;
    logic           ex_valid;
    logic [ExW-1:0] ex;
  } exec_result_t;
endpackage

module commit_stage
  import commit_pkg::*;
#(
  parameter int unsigned Depth       = 2,
  parameter int unsigned FlushCycles = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  exec_result_t       in_data_i,
  output logic               rf_we_o,
  output logic [4:0]         rf_waddr_o,
  output logic [31:0]        rf_wdata_o,
  output logic               redirect_valid_o,
  output logic [31:0]        redirect_target_o,
  output logic               ret_pulse_o,
  output logic               trap_valid_o,
  output logic [ExW-1:0]     trap_ex_o,
  input  logic               trap_ack_i,
  output logic               busy_o
`ifdef COMMIT_PERF_EN
  ,
  output logic [63:0]        perf_retired_o,
  output logic [31:0]        perf_flushes_o
`endif
);

  localparam int unsigned AW   = $clog2(Depth);
  localparam int unsigned PtrW = AW + 1;
  localparam int unsigned CntW = (FlushCycles > 1) ? $clog2(FlushCycles) : 1;

  typedef enum logic [1:0] {StRun, StFlush, StHalt} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [PtrW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  exec_result_t      mem_q [Depth];
  exec_result_t      head;

  logic              rf_we_q, rf_we_d;
  logic [4:0]        rf_waddr_q, rf_waddr_d;
  logic [31:0]       rf_wdata_q, rf_wdata_d;
  logic              redirect_valid_q, redirect_valid_d;
  logic [31:0]       redirect_target_q, redirect_target_d;
  logic              ret_pulse_q, ret_pulse_d;
  logic              trap_valid_q, trap_valid_d;
  logic [ExW-1:0]    trap_ex_q, trap_ex_d;

  logic              empty, full, pop, push;

`ifdef COMMIT_PERF_EN
  logic [63:0]       retired_q, retired_d;
  logic [31:0]       flushes_q, flushes_d;
`endif

  // FIFO status, handshake and pop decision; in_ready never depends on in_valid.
  always_comb begin
    empty      = (wptr_q == rptr_q);
    full       = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
    pop        = (state_q == StRun) && !empty;
    in_ready_o = !rst_i && (state_q == StRun) && (!full || pop);
    push       = in_valid_i && in_ready_o;
    head       = mem_q[rptr_q[AW-1:0]];
    busy_o     = !empty || (state_q != StRun);
  end

  // Next-state logic for the FSM, pointers and registered commit outputs.
  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    wptr_d            = push ? wptr_q + PtrW'(1) : wptr_q;
    rptr_d            = pop ? rptr_q + PtrW'(1) : rptr_q;
    rf_we_d           = 1'b0;
    rf_waddr_d        = '0;
    rf_wdata_d        = '0;
    redirect_valid_d  = 1'b0;
    redirect_target_d = '0;
    ret_pulse_d       = 1'b0;
    trap_valid_d      = trap_valid_q;
    trap_ex_d         = trap_ex_q;

    unique case (state_q)
      StRun: begin
        if (pop) begin
          rf_we_d    = (head.rd_idx != 5'd0) && !head.ex_valid;
          rf_waddr_d = head.rd_idx;
          rf_wdata_d = head.rd_val;
          if (head.ex_valid) begin
            trap_valid_d = 1'b1;
            trap_ex_d    = head.ex;
            state_d      = StHalt;
            // Discard everything queued behind the trap, including a same-cycle push.
            wptr_d       = '0;
            rptr_d       = '0;
          end else if (head.br_valid) begin
            redirect_valid_d  = 1'b1;
            redirect_target_d = head.br_target;
            state_d           = StFlush;
            cnt_d             = CntW'(FlushCycles - 1);
            wptr_d            = '0;
            rptr_d            = '0;
          end else if (head.ret_valid) begin
            ret_pulse_d = 1'b1;
          end
        end
      end
      StFlush: begin
        if (cnt_q == '0) begin
          state_d = StRun;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StHalt: begin
        if (trap_ack_i) begin
          trap_valid_d = 1'b0;
          state_d      = StRun;
        end
      end
      default: state_d = StRun;
    endcase
  end

`ifdef COMMIT_PERF_EN
  // Retired count saturates; flush count wraps.
  always_comb begin
    retired_d = retired_q;
    flushes_d = flushes_q;
    if (pop && !head.ex_valid && (retired_q != '1)) begin
      retired_d = retired_q + 64'd1;
    end
    if (pop && !head.ex_valid && head.br_valid) begin
      flushes_d = flushes_q + 32'd1;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      retired_q <= '0;
      flushes_q <= '0;
    end else begin
      retired_q <= retired_d;
      flushes_q <= flushes_d;
    end
  end

  assign perf_retired_o = retired_q;
  assign perf_flushes_o = flushes_q;
`endif

  // FIFO storage; payload only, so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wptr_q[AW-1:0]] <= in_data_i;
    end
  end

  // State, pointers and registered outputs with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q           <= StRun;
      cnt_q             <= '0;
      wptr_q            <= '0;
      rptr_q            <= '0;
      rf_we_q           <= 1'b0;
      rf_waddr_q        <= '0;
      rf_wdata_q        <= '0;
      redirect_valid_q  <= 1'b0;
      redirect_target_q <= '0;
      ret_pulse_q       <= 1'b0;
      trap_valid_q      <= 1'b0;
      trap_ex_q         <= '0;
    end else begin
      state_q           <= state_d;
      cnt_q             <= cnt_d;
      wptr_q            <= wptr_d;
      rptr_q            <= rptr_d;
      rf_we_q           <= rf_we_d;
      rf_waddr_q        <= rf_waddr_d;
      rf_wdata_q        <= rf_wdata_d;
      redirect_valid_q  <= redirect_valid_d;
      redirect_target_q <= redirect_target_d;
      ret_pulse_q       <= ret_pulse_d;
      trap_valid_q      <= trap_valid_d;
      trap_ex_q         <= trap_ex_d;
    end
  end

  assign rf_we_o           = rf_we_q;
  assign rf_waddr_o        = rf_waddr_q;
  assign rf_wdata_o        = rf_wdata_q;
  assign redirect_valid_o  = redirect_valid_q;
  assign redirect_target_o = redirect_target_q;
  assign ret_pulse_o       = ret_pulse_q;
  assign trap_valid_o      = trap_valid_q;
  assign trap_ex_o         = trap_ex_q;

endmodule

// File: tb/tb_commit_stage.sv
// Scoreboard bench for commit_stage: expected commit records are queued as packets are
// accepted and compared when the DUT raises a commit output.

module tb_commit_stage;
  import commit_pkg::*;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  exec_result_t   in_data;
  logic           rf_we;
  logic [4:0]     rf_waddr;
  logic [31:0]    rf_wdata;
  logic           redirect_valid;
  logic [31:0]    redirect_target;
  logic           ret_pulse;
  logic           trap_valid;
  logic [ExW-1:0] trap_ex;
  logic           trap_ack;
  logic           busy;
`ifdef COMMIT_PERF_EN
  logic [63:0]    perf_retired;
  logic [31:0]    perf_flushes;
`endif

  commit_stage dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .in_valid_i        (in_valid),
    .in_ready_o        (in_ready),
    .in_data_i         (in_data),
    .rf_we_o           (rf_we),
    .rf_waddr_o        (rf_waddr),
    .rf_wdata_o        (rf_wdata),
    .redirect_valid_o  (redirect_valid),
    .redirect_target_o (redirect_target),
    .ret_pulse_o       (ret_pulse),
    .trap_valid_o      (trap_valid),
    .trap_ex_o         (trap_ex),
    .trap_ack_i        (trap_ack),
    .busy_o            (busy)
`ifdef COMMIT_PERF_EN
    ,
    .perf_retired_o    (perf_retired),
    .perf_flushes_o    (perf_flushes)
`endif
  );

  always #5 clk = ~clk;

  int unsigned n_vec  = 0;
  int unsigned n_fail = 0;
  logic [80:0] exp_q[$];
  logic        dropping = 1'b0;
  logic        trap_prev = 1'b0;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [80:0] rec(input logic we, input logic [4:0] a, input logic [31:0] d,
                                      input logic rv, input logic [31:0] t, input logic rp,
                                      input logic tv, input logic [7:0] ex);
    return {we, a, d, rv, t, rp, tv, ex};
  endfunction

  function automatic exec_result_t pkt(input logic [4:0] rd, input logic [31:0] val,
                                       input logic br, input logic [31:0] tgt, input logic ret,
                                       input logic exv, input logic [7:0] ex);
    exec_result_t p;
    p.rd_idx = rd; p.rd_val = val; p.br_valid = br; p.br_target = tgt;
    p.ret_valid = ret; p.ex_valid = exv; p.ex = ex;
    return p;
  endfunction

  // Monitor: any commit pulse or a rising trap must match the next scoreboard entry.
  always @(negedge clk) begin
    if (rf_we || redirect_valid || ret_pulse || (trap_valid && !trap_prev)) begin
      logic [80:0] obs;
      obs = rec(rf_we, rf_waddr, rf_wdata, redirect_valid, redirect_target, ret_pulse,
                trap_valid, trap_valid ? trap_ex : 8'h0);
      if (exp_q.size() == 0) check_eq("spurious_commit", {47'h0, obs}, 128'h0);
      else check_eq("commit", {47'h0, obs}, {47'h0, exp_q.pop_front()});
    end
    trap_prev <= trap_valid;
  end

  // Drive one packet (called at a negedge), wait for in_ready, record the expected commit.
  task automatic push(input exec_result_t p, output int waited);
    waited   = 0;
    in_valid = 1'b1;
    in_data  = p;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) check_eq("push_timeout", 0, 1);
    @(posedge clk);
    if (!dropping) begin
      if (p.ex_valid) begin
        exp_q.push_back(rec(1'b0, p.rd_idx, p.rd_val, 1'b0, 32'h0, 1'b0, 1'b1, p.ex));
        dropping = 1'b1;
      end else if (p.br_valid) begin
        exp_q.push_back(rec(p.rd_idx != 0, p.rd_idx, p.rd_val, 1'b1, p.br_target, 1'b0,
                            1'b0, 8'h0));
        dropping = 1'b1;
      end else if (p.rd_idx != 0 || p.ret_valid) begin
        exp_q.push_back(rec(p.rd_idx != 0, p.rd_idx, p.rd_val, 1'b0, 32'h0, p.ret_valid,
                            1'b0, 8'h0));
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Wait for the pipeline to drain and all expected commits to be seen.
  task automatic settle();
    int n = 0;
    repeat (3) @(negedge clk);
    while ((busy || !in_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("settle_idle", {busy, in_ready}, 2'b01);
    check_eq("sb_empty", exp_q.size(), 0);
    dropping = 1'b0;
  endtask

  task automatic wait_trap();
    int n = 0;
    while (!trap_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check_eq("trap_seen", trap_valid, 1);
  endtask

  initial begin
    int w, n;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; trap_ack = 1'b0;
    @(negedge clk);
    check_eq("rdy_in_reset", in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("reset_outs", {rf_we, rf_waddr, rf_wdata, redirect_valid, redirect_target,
                            ret_pulse, trap_valid, trap_ex, busy}, 0);
    check_eq("reset_rdy", in_ready, 1);
    @(negedge clk);

    // Single write, latency and busy
    push(pkt(5'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0), w);
    n = 0;
    while (!rf_we && n < 5) begin
      @(negedge clk);
      n++;
    end
    check_eq("wr_latency", n, 1);
    check_eq("busy_after_wr", busy, 0);
    settle();

    // Write to x0 is silent
    push(pkt(5'd0, 32'h1234, 0, 0, 0, 0, 0), w);
    settle();

    // Back-to-back pushes, in_ready never drops
    for (int i = 0; i < 8; i++) begin
      push(pkt(5'(i + 10), 32'hA000_0000 + i, 0, 0, 0, 0, 0), w);
      check_eq("b2b_ready", w, 0);
    end
    settle();

    // Return pulse, then branch+ret priority
    push(pkt(5'd9, 32'h99, 0, 0, 1, 0, 0), w);
    settle();

    // Branch: x3 written, rd=4 discarded, FLUSH lasts two cycles
    push(pkt(5'd3, 32'h33, 1, 32'h80000040, 0, 0, 0), w);
    push(pkt(5'd4, 32'h44, 0, 0, 0, 0, 0), w);
    n = 0;
    while (!in_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    check_eq("flush_len", n, 2);
    settle();

    push(pkt(5'd0, 32'h55, 1, 32'h0000_1000, 1, 0, 0), w);
    settle();

    // Exception: held trap, no write, ack resumes
    push(pkt(5'd7, 32'h77, 1, 32'h4, 1, 1, 8'd2), w);
    wait_trap();
    repeat (3) begin
      check_eq("halt_hold", {trap_valid, trap_ex, in_ready, busy, rf_we}, {1'b1, 8'd2, 3'b010});
      @(negedge clk);
    end
    trap_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    trap_ack = 1'b0;
    check_eq("trap_ack_resume", {trap_valid, in_ready}, 2'b01);
    dropping = 1'b0;

    // trap_ack outside HALT has no effect
    trap_ack = 1'b1;
    push(pkt(5'd6, 32'h66, 0, 0, 0, 0, 0), w);
    trap_ack = 1'b0;
    settle();

    // Reset while halted
    push(pkt(5'd1, 32'h11, 0, 0, 0, 1, 8'd5), w);
    wait_trap();
    rst = 1'b1;
    #1;
    check_eq("rdy_in_reset2", in_ready, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    dropping = 1'b0;
    #1;
    check_eq("halt_reset", {trap_valid, trap_ex, busy, in_ready}, {1'b0, 8'd0, 2'b01});
    @(negedge clk);
    push(pkt(5'd12, 32'hC0FFEE, 0, 0, 0, 0, 0), w);
    settle();

    // Random plain/return packets with idle gaps
    for (int i = 0; i < 10; i++) begin
      push(pkt(5'($urandom_range(0, 31)), $urandom, 0, 0, 1'($urandom_range(0, 1)), 0, 0), w);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    settle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/commit_stage.md
Name: commit_stage

Overview:
- Downstream neighbour of the ALU. Consumes exec_result packets over a valid/ready handshake and buffers them in a small in-order FIFO.
- Retires one packet per cycle: register-file write, branch redirect, return signalling or trap entry.
- Owns the post-redirect flush sequencing and the halt-on-exception state seen by the frontend.

Parameters:
- DEPTH, 2, result FIFO entries; power of two, >= 2.
- FLUSH_CYCLES, 2, minimum cycles spent in FLUSH after a redirect before upstream results are accepted again.

Ports:
- clk  input  1  core clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  exec_result valid from the execute stage.
- in_ready  output  1  commit_stage can accept in_data this cycle.
- in_data  input  exec_result  result packet (rd_idx, rd_val, br_valid, br_target, ret_valid, ex_valid, ex).
- rf_we  output  1  register-file write enable.
- rf_waddr  output  5  write index.
- rf_wdata  output  32  write data.
- redirect_valid  output  1  one-cycle pulse: fetch must restart at redirect_target.
- redirect_target  output  32  new PC.
- ret_pulse  output  1  one-cycle pulse: a return instruction committed.
- trap_valid  output  1  level: exception committed; core halted.
- trap_ex  output  width of exec_result.ex  latched exception payload.
- trap_ack  input  1  trap handler accepted; resume.
- busy  output  1  FIFO non-empty or state != RUN.

Behaviour:
- Reset (rst=1 at a posedge):
  - FIFO emptied, state = RUN.
  - All outputs 0, trap_ex = 0.
  - in_ready = 0 during the reset cycle.
- Handshake:
  - Enqueue on in_valid && in_ready.
  - in_ready = (state==RUN) && (!full || pop this cycle); simultaneous push+pop on a full FIFO is allowed.
  - in_data is sampled only on a handshake; no combinational path from in_valid to in_ready.
- FIFO: read/write pointers of log2(DEPTH)+1 bits; wrap-around by pointer MSB; full when the indices match and the MSBs differ.
- Pop: in RUN, the head is popped every cycle the FIFO is non-empty. A packet pushed at cycle N reaches its outputs no earlier than cycle N+1 (registered outputs, 1-cycle latency when empty).
- On popping head H, registered outputs in the next cycle:
  - rf_we = (H.rd_idx != 0) && !H.ex_valid; rf_waddr = H.rd_idx; rf_wdata = H.rd_val. Writes to x0 are suppressed.
  - If H.ex_valid: trap_valid=1, trap_ex=H.ex, state -> HALT; all other FIFO entries discarded.
  - Else if H.br_valid: redirect_valid=1 for exactly one cycle, redirect_target=H.br_target, remaining entries discarded, state -> FLUSH.
  - Else if H.ret_valid: ret_pulse=1 for one cycle; state unchanged.
- ex_valid takes priority over br_valid and ret_valid. br_valid takes priority over ret_valid; ret_pulse is not raised then.
- States:
  - RUN: normal operation as above.
  - FLUSH: in_ready=0, FIFO empty. Counter loads FLUSH_CYCLES-1 and decrements; at 0 -> RUN. No rf_we, redirect or ret pulses in FLUSH.
  - HALT: in_ready=0. trap_valid held at 1. When trap_ack is sampled 1: next cycle trap_valid=0, state -> RUN. trap_ack outside HALT is ignored.
- Outputs other than trap_valid and trap_ex deassert in any cycle without a pop.
- rst asserted mid-FLUSH or mid-HALT returns the block to RUN, empty, with all outputs 0.

Optional Feature:
- Macro: COMMIT_PERF_EN.
- Defined:
  - Adds output perf_retired [63:0], counting popped packets that did not trap, saturating at all-ones.
  - Adds output perf_flushes [31:0], counting redirects, wrapping.
  - Both reset to 0 and are readable any cycle.
- Undefined: neither port nor counter exists; behaviour otherwise identical.

Test Plan:
- Reset then push {rd=5, val=32'hDEADBEEF} -> one cycle later rf_we=1, rf_waddr=5, rf_wdata=32'hDEADBEEF; busy falls afterwards.
- Push {rd=0, val=32'h1234} -> rf_we stays 0, no other output.
- DEPTH=2 back-to-back pushes with in_valid held high for 8 cycles -> in_ready stays 1, 8 consecutive writes in order, no drops.
- Push {rd=3, br_valid=1, target=32'h80000040} followed by {rd=4} -> x3 written; redirect_valid pulses once with target 32'h80000040; the rd=4 entry is discarded; in_ready=0 for FLUSH_CYCLES cycles, then 1.
- Push {ex_valid=1, ex=cause 2, rd=7} -> no rf write; trap_valid held high with trap_ex=2 until trap_ack; one cycle after trap_ack, trap_valid=0 and in_ready=1.
- Assert rst while in HALT -> next cycle trap_valid=0, busy=0, in_ready=1; a subsequent push commits normally.
